// File: rtl/dmem_responder.sv
// Data-memory slave for the single-cycle core: word RAM plus a 16-word MMIO window.
// Optional macro DMEM_WRITE_PROTECT_EN makes RAM words [0, RO_LIMIT) read-only.
module dmem_responder #(
  parameter int                    SIZE       = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 'h3F0,
  parameter int                    RO_LIMIT   = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [SIZE-1:0]       ddata_w,
  input  logic                  d_rw,
  output logic [SIZE-1:0]       ddata_r,
  output logic [SIZE-1:0]       gpio_out,
  output logic                  halt,
  output logic [SIZE-1:0]       halt_code,
  output logic                  wp_fault
);

  localparam logic [3:0] OFF_CYC_LO  = 4'h0;
  localparam logic [3:0] OFF_CYC_HI  = 4'h1;
  localparam logic [3:0] OFF_STORES  = 4'h2;
  localparam logic [3:0] OFF_GPIO    = 4'h4;
  localparam logic [3:0] OFF_GPIO_S  = 4'h5;
  localparam logic [3:0] OFF_GPIO_C  = 4'h6;
  localparam logic [3:0] OFF_SCRATCH = 4'h7;
  localparam logic [3:0] OFF_TOHOST  = 4'h8;

  // Window must be 16-aligned so the upper-bit decode covers exactly 16 words.
  if (MMIO_BASE[3:0] != 4'd0 || RO_LIMIT < 0) begin : g_bad_param
    $error("dmem_responder: MMIO_BASE must be 16-aligned and RO_LIMIT non-negative");
  end

  logic [SIZE-1:0] ram [0:(2**ADDR_WIDTH)-1];
  logic [63:0]     cyc;
  logic [SIZE-1:0] store_cnt;
  logic [SIZE-1:0] scratch;

  logic       is_mmio;
  logic [3:0] off;
  logic       ram_ok;
  logic       wr_ram;
  logic       wr_mmio;
  logic       accept;

  assign is_mmio = (daddr[ADDR_WIDTH-1:4] == MMIO_BASE[ADDR_WIDTH-1:4]);
  assign off     = daddr[3:0];

`ifdef DMEM_WRITE_PROTECT_EN
  assign ram_ok = !(int'(daddr) < RO_LIMIT);
`else
  assign ram_ok = 1'b1;
`endif

  assign wr_ram = d_rw && !is_mmio && ram_ok;

  // Only writable offsets count; a TOHOST write after halt is ignored.
  always_comb begin
    wr_mmio = 1'b0;
    if (d_rw && is_mmio) begin
      case (off)
        OFF_GPIO, OFF_GPIO_S, OFF_GPIO_C, OFF_SCRATCH: wr_mmio = 1'b1;
        OFF_TOHOST:                                    wr_mmio = !halt;
        default:                                       wr_mmio = 1'b0;
      endcase
    end
  end

  assign accept = wr_ram || wr_mmio;

  // Reads are side-effect free: the core drives daddr every instruction.
  always_comb begin
    ddata_r = '0;
    if (is_mmio) begin
      case (off)
        OFF_CYC_LO:  ddata_r = SIZE'(cyc[31:0]);
        OFF_CYC_HI:  ddata_r = SIZE'(cyc[63:32]);
        OFF_STORES:  ddata_r = store_cnt;
        OFF_GPIO:    ddata_r = gpio_out;
        OFF_SCRATCH: ddata_r = scratch;
        OFF_TOHOST:  ddata_r = halt_code;
        default:     ddata_r = '0;
      endcase
    end else begin
      ddata_r = ram[daddr];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ram) ram[daddr] <= ddata_w;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cyc       <= '0;
      store_cnt <= '0;
      gpio_out  <= '0;
      scratch   <= '0;
      halt      <= 1'b0;
      halt_code <= '0;
    end else begin
      if (!halt) cyc <= cyc + 64'd1;
      if (accept && !halt) store_cnt <= store_cnt + SIZE'(1);
      if (wr_mmio) begin
        case (off)
          OFF_GPIO:    gpio_out <= ddata_w;
          OFF_GPIO_S:  gpio_out <= gpio_out | ddata_w;
          OFF_GPIO_C:  gpio_out <= gpio_out & ~ddata_w;
          OFF_SCRATCH: scratch  <= ddata_w;
          OFF_TOHOST: begin
            halt      <= 1'b1;
            halt_code <= ddata_w;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DMEM_WRITE_PROTECT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                       wp_fault <= 1'b0;
    else if (d_rw && !is_mmio && !ram_ok) wp_fault <= 1'b1;
  end
`else
  assign wp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int K_RD = 0, K_GPIO = 1, K_HALT = 2, K_CODE = 3, K_WP = 4;

`ifdef DMEM_WRITE_PROTECT_EN
  localparam int   WPD = 0;
  localparam logic WPV = 1'b1;
`else
  localparam int   WPD = 1;
  localparam logic WPV = 1'b0;
`endif

  logic        CLK, RESET_N, d_rw;
  logic [9:0]  daddr;
  logic [31:0] ddata_w, ddata_r, gpio_out, halt_code;
  logic        halt, wp_fault;

  dmem_responder #(.SIZE(32), .ADDR_WIDTH(10), .MMIO_BASE(10'h3F0), .RO_LIMIT(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw),
    .ddata_r(ddata_r), .gpio_out(gpio_out), .halt(halt), .halt_code(halt_code),
    .wp_fault(wp_fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          step;
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   step = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
    step++;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    tick();
    d_rw = 1'b1; daddr = a; ddata_w = d;
  endtask

  task automatic rd(input logic [9:0] a);
    tick();
    d_rw = 1'b0; daddr = a;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.step = step; c.kind = kind; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  always @(negedge CLK) begin
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].step <= step) begin
      chk_t c;
      c = sb.pop_front();
      case (c.kind)
        K_RD:    act = ddata_r;
        K_GPIO:  act = gpio_out;
        K_HALT:  act = {31'd0, halt};
        K_CODE:  act = halt_code;
        default: act = {31'd0, wp_fault};
      endcase
      tests++;
      if (c.step != step || act !== c.exp) begin
        fails++;
        $display("FAIL %s (step %0d at %0d): got 0x%08h, expected 0x%08h",
                 c.name, c.step, step, act, c.exp);
      end
    end
  end

  int hv;

  initial begin
    RESET_N = 1'b0; d_rw = 1'b0; daddr = '0; ddata_w = '0;

    rd(10'h3F0);
    expect_v(K_RD, 32'd0, "rst_cycle");
    expect_v(K_HALT, 32'd0, "rst_halt");
    expect_v(K_CODE, 32'd0, "rst_code");
    expect_v(K_GPIO, 32'd0, "rst_gpio");
    expect_v(K_WP, 32'd0, "rst_wp");
    tick(); RESET_N = 1'b1;
    repeat (9) tick();
    rd(10'h3F0); expect_v(K_RD, 32'd10, "cycle_lo_10");
    rd(10'h3F1); expect_v(K_RD, 32'd0, "cycle_hi");
    expect_v(K_HALT, 32'd0, "halt_idle"); expect_v(K_GPIO, 32'd0, "gpio_idle");
    rd(10'h3F2); expect_v(K_RD, 32'd0, "stores_0");

    wr(10'h005, 32'h1111_1111);
    wr(10'h005, 32'hDEAD_BEEF); expect_v(K_RD, 32'h1111_1111, "rdw_old");
    rd(10'h005); expect_v(K_RD, 32'hDEAD_BEEF, "ram_new");
    rd(10'h3F2); expect_v(K_RD, 32'd2, "stores_2");

    wr(10'h3F4, 32'h0F); expect_v(K_GPIO, 32'h00, "gpio_pre");
    wr(10'h3F5, 32'hF0); expect_v(K_GPIO, 32'h0F, "gpio_wr"); expect_v(K_RD, 32'd0, "gpio_set_rd");
    wr(10'h3F6, 32'h0F); expect_v(K_GPIO, 32'hFF, "gpio_set");
    rd(10'h3F5); expect_v(K_GPIO, 32'hF0, "gpio_clr"); expect_v(K_RD, 32'd0, "gpio_set_rd0");
    rd(10'h3F4); expect_v(K_RD, 32'hF0, "gpio_rd");

    wr(10'h3FC, 32'h1234);
    rd(10'h3FC); expect_v(K_RD, 32'd0, "unmapped_rd");
    rd(10'h3F2); expect_v(K_RD, 32'd5, "stores_unmapped");
    wr(10'h3F7, 32'hA5A5_A5A5);
    rd(10'h3F7); expect_v(K_RD, 32'hA5A5_A5A5, "scratch");
    rd(10'h3F2); expect_v(K_RD, 32'd6, "stores_scratch");
    wr(10'h3F0, 32'd1);
    rd(10'h3F2); expect_v(K_RD, 32'd6, "stores_ro");
    rd(10'h3F0); expect_v(K_RD, 32'(step - 2), "cycle_ro_wr");

    wr(10'h004, 32'h55);
    rd(10'h004);
    if (WPD == 1) expect_v(K_RD, 32'h55, "ram_low_wr");
    expect_v(K_WP, {31'd0, WPV}, "wp_fault");
    rd(10'h3F2); expect_v(K_RD, 32'(6 + WPD), "stores_wp");
    wr(10'h010, 32'h55);
    rd(10'h010); expect_v(K_RD, 32'h55, "ram_16");
    rd(10'h3F2); expect_v(K_RD, 32'(7 + WPD), "stores_16");

    wr(10'h3F8, 32'd1); expect_v(K_HALT, 32'd0, "halt_pre");
    hv = step - 1;
    rd(10'h3F0); expect_v(K_RD, 32'(hv), "cycle_at_halt");
    expect_v(K_HALT, 32'd1, "halt_set"); expect_v(K_CODE, 32'd1, "halt_code");
    wr(10'h3F8, 32'd2);
    rd(10'h3F8); expect_v(K_RD, 32'd1, "tohost_rd"); expect_v(K_CODE, 32'd1, "code_sticky");
    rd(10'h3F0); expect_v(K_RD, 32'(hv), "cycle_frozen");
    rd(10'h3F2); expect_v(K_RD, 32'(8 + WPD), "stores_halt");
    wr(10'h020, 32'h77);
    rd(10'h020); expect_v(K_RD, 32'h77, "ram_after_halt");
    rd(10'h3F2); expect_v(K_RD, 32'(8 + WPD), "stores_frozen");
    wr(10'h3F4, 32'h3);
    rd(10'h3F4); expect_v(K_GPIO, 32'h3, "gpio_after_halt"); expect_v(K_RD, 32'h3, "gpio_rd_halt");

    rd(10'h3F0);
    #2 RESET_N = 1'b0;
    expect_v(K_HALT, 32'd0, "mid_rst_halt"); expect_v(K_CODE, 32'd0, "mid_rst_code");
    expect_v(K_GPIO, 32'd0, "mid_rst_gpio"); expect_v(K_RD, 32'd0, "mid_rst_cycle");
    expect_v(K_WP, 32'd0, "mid_rst_wp");
    tick(); RESET_N = 1'b1;
    rd(10'h3F0); expect_v(K_RD, 32'd1, "cycle_restart");
    rd(10'h3F7); expect_v(K_RD, 32'd0, "scratch_rst");
    rd(10'h3F2); expect_v(K_RD, 32'd0, "stores_rst");

    repeat (2) @(negedge CLK);
    #1;
    while (sb.size() > 0) begin
      chk_t c;
      c = sb.pop_front();
      tests++; fails++;
      $display("FAIL %s: never checked, expected 0x%08h", c.name, c.exp);
    end
    tests++;
    if (halt !== 1'b0) begin
      fails++; $display("FAIL end_halt: got %b", halt);
    end
    tests++;
    if (halt_code !== 32'd0) begin
      fails++; $display("FAIL end_code: got 0x%08h", halt_code);
    end
    tests++;
    if (gpio_out !== 32'd0) begin
      fails++; $display("FAIL end_gpio: got 0x%08h", gpio_out);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
